// File: rtl/mem_port_arbiter_pkg.sv
// Shared definitions for the two-port memory arbiter: state encoding, port ids,
// default widths and the access-counter width.
package mem_port_arbiter_pkg;

    localparam int ADDR_W_DEF = 16;
    localparam int DATA_W_DEF = 16;
    localparam int CNT_W      = 4;

    localparam logic PORT_FETCH = 1'b0;
    localparam logic PORT_DATA  = 1'b1;

    localparam logic [CNT_W-1:0] CNT_ZERO = 4'd0;
    localparam logic [CNT_W-1:0] CNT_ONE  = 4'd1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } state_t;

    // Counter preload so that the enable stays high for exactly lat cycles.
    function automatic logic [CNT_W-1:0] lat_load(input int lat);
        return CNT_W'(lat - 1);
    endfunction

endpackage

// File: rtl/mem_port_arbiter_arb_pick2.sv
// Two-request selector: a tie goes to the port that was not granted last;
// a single request always wins.
module arb_pick2
    import mem_port_arbiter_pkg::*;
(
    input  logic req0,
    input  logic req1,
    input  logic last_grant,
    output logic grant_valid,
    output logic grant_id
);

    // Grant selection; a fixed-priority caller ties last_grant to PORT_FETCH.
    always_comb begin
        grant_valid = req0 | req1;
        if (req0 && req1) begin
            grant_id = ~last_grant;
        end else if (req1) begin
            grant_id = PORT_DATA;
        end else begin
            grant_id = PORT_FETCH;
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-port memory between instruction fetch (port 0) and the
// load/store datapath (port 1). Define ARB_ROUND_ROBIN_EN for round-robin ties.
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int ADDR_W  = ADDR_W_DEF,
    parameter int DATA_W  = DATA_W_DEF,
    parameter int MEM_LAT = 1
) (
    input  logic              clk,
    input  logic              In_reset,
    input  logic              In_req0,
    input  logic              In_rwbar0,
    input  logic [ADDR_W-1:0] In_addr0,
    input  logic [DATA_W-1:0] In_wdata0,
    output logic              Out_ack0,
    output logic [DATA_W-1:0] Out_rdata0,
    input  logic              In_req1,
    input  logic              In_rwbar1,
    input  logic [ADDR_W-1:0] In_addr1,
    input  logic [DATA_W-1:0] In_wdata1,
    output logic              Out_ack1,
    output logic [DATA_W-1:0] Out_rdata1,
    output logic              Out_Mem_Access_en,
    output logic              Out_Mem_Access_R_Wbar,
    output logic [ADDR_W-1:0] Out_Mem_Access_addr,
    output logic [DATA_W-1:0] Out_Mem_Write_data,
    input  logic [DATA_W-1:0] In_Mem_Read_data,
    output logic              Out_busy
);

    localparam logic [CNT_W-1:0] CNT_LOAD = lat_load(MEM_LAT);

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              win_id_q, win_id_d;
    logic              en_q, en_d;
    logic              rwbar_q, rwbar_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic              ack0_q, ack0_d;
    logic              ack1_q, ack1_d;
    logic [DATA_W-1:0] rdata0_q, rdata0_d;
    logic [DATA_W-1:0] rdata1_q, rdata1_d;
    logic              busy_q, busy_d;

    logic              grant_valid_s;
    logic              grant_id_s;
    logic              last_grant_s;

`ifdef ARB_ROUND_ROBIN_EN
    logic              last_grant_q, last_grant_d;

    // Last-grant pointer; resets to the data port so fetch wins the first tie.
    always_ff @(posedge clk or negedge In_reset) begin
        if (!In_reset) begin
            last_grant_q <= PORT_DATA;
        end else begin
            last_grant_q <= last_grant_d;
        end
    end

    // Pointer follows every grant taken in IDLE.
    always_comb begin
        last_grant_d = last_grant_q;
        if (state_q == IDLE && grant_valid_s) begin
            last_grant_d = grant_id_s;
        end else begin
            last_grant_d = last_grant_q;
        end
    end

    assign last_grant_s = last_grant_q;
`else
    assign last_grant_s = PORT_FETCH;
`endif

    arb_pick2 u_pick (
        .req0        (In_req0),
        .req1        (In_req1),
        .last_grant  (last_grant_s),
        .grant_valid (grant_valid_s),
        .grant_id    (grant_id_s)
    );

    // Next-state and next-output computation for the IDLE/ACCESS/DONE sequence.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        win_id_d = win_id_q;
        en_d     = en_q;
        rwbar_d  = rwbar_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        ack0_d   = 1'b0;
        ack1_d   = 1'b0;
        rdata0_d = rdata0_q;
        rdata1_d = rdata1_q;
        busy_d   = busy_q;

        case (state_q)
            IDLE: begin
                if (grant_valid_s) begin
                    state_d  = ACCESS;
                    cnt_d    = CNT_LOAD;
                    win_id_d = grant_id_s;
                    en_d     = 1'b1;
                    busy_d   = 1'b1;
                    rwbar_d  = (grant_id_s == PORT_DATA) ? In_rwbar1 : In_rwbar0;
                    addr_d   = (grant_id_s == PORT_DATA) ? In_addr1  : In_addr0;
                    wdata_d  = (grant_id_s == PORT_DATA) ? In_wdata1 : In_wdata0;
                end else begin
                    en_d     = 1'b0;
                    busy_d   = 1'b0;
                end
            end
            ACCESS: begin
                if (cnt_q == CNT_ZERO) begin
                    state_d = DONE;
                    en_d    = 1'b0;
                    rwbar_d = 1'b1;
                    ack0_d  = (win_id_q == PORT_FETCH);
                    ack1_d  = (win_id_q == PORT_DATA);
                    // Read data is taken on the edge that closes the access window.
                    if (rwbar_q && win_id_q == PORT_DATA) begin
                        rdata1_d = In_Mem_Read_data;
                    end else if (rwbar_q) begin
                        rdata0_d = In_Mem_Read_data;
                    end else begin
                        rdata0_d = rdata0_q;
                    end
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end
            DONE: begin
                state_d = IDLE;
                en_d    = 1'b0;
                busy_d  = 1'b0;
            end
            default: begin
                state_d = IDLE;
                en_d    = 1'b0;
                rwbar_d = 1'b1;
                busy_d  = 1'b0;
            end
        endcase
    end

    // State and registered outputs; async reset abandons any access in flight.
    always_ff @(posedge clk or negedge In_reset) begin
        if (!In_reset) begin
            state_q  <= IDLE;
            cnt_q    <= CNT_ZERO;
            win_id_q <= PORT_FETCH;
            en_q     <= 1'b0;
            rwbar_q  <= 1'b1;
            addr_q   <= {ADDR_W{1'b0}};
            wdata_q  <= {DATA_W{1'b0}};
            ack0_q   <= 1'b0;
            ack1_q   <= 1'b0;
            rdata0_q <= {DATA_W{1'b0}};
            rdata1_q <= {DATA_W{1'b0}};
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            win_id_q <= win_id_d;
            en_q     <= en_d;
            rwbar_q  <= rwbar_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            ack0_q   <= ack0_d;
            ack1_q   <= ack1_d;
            rdata0_q <= rdata0_d;
            rdata1_q <= rdata1_d;
            busy_q   <= busy_d;
        end
    end

    assign Out_ack0              = ack0_q;
    assign Out_ack1              = ack1_q;
    assign Out_rdata0            = rdata0_q;
    assign Out_rdata1            = rdata1_q;
    assign Out_Mem_Access_en     = en_q;
    assign Out_Mem_Access_R_Wbar = rwbar_q;
    assign Out_Mem_Access_addr   = addr_q;
    assign Out_Mem_Write_data    = wdata_q;
    assign Out_busy              = busy_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: one instance at MEM_LAT=1 backed by a small
// RAM model, one at MEM_LAT=3 backed by an address-derived read pattern.
module tb_mem_port_arbiter;

    logic clk = 1'b0;
    logic rst_n;

    logic        req0_a, rwbar0_a, req1_a, rwbar1_a;
    logic [15:0] addr0_a, wdata0_a, addr1_a, wdata1_a;
    logic        ack0_a, ack1_a, en_a, rw_a, busy_a;
    logic [15:0] rdata0_a, rdata1_a, maddr_a, mwdata_a, mrdata_a;

    logic        req0_b, rwbar0_b, req1_b, rwbar1_b;
    logic [15:0] addr0_b, wdata0_b, addr1_b, wdata1_b;
    logic        ack0_b, ack1_b, en_b, rw_b, busy_b;
    logic [15:0] rdata0_b, rdata1_b, maddr_b, mwdata_b, mrdata_b;

    int n_checks = 0;
    int n_errors = 0;

    logic [15:0] mem_a [0:63] = '{default: 16'h0000};

    always #5 clk = ~clk;

    assign mrdata_a = mem_a[maddr_a[5:0]];
    always @(posedge clk) begin
        if (en_a && !rw_a) mem_a[maddr_a[5:0]] <= mwdata_a;
    end
    assign mrdata_b = maddr_b ^ 16'hA5A5;

    mem_port_arbiter #(.MEM_LAT(1)) u_dut_a (
        .clk(clk), .In_reset(rst_n),
        .In_req0(req0_a), .In_rwbar0(rwbar0_a), .In_addr0(addr0_a), .In_wdata0(wdata0_a),
        .Out_ack0(ack0_a), .Out_rdata0(rdata0_a),
        .In_req1(req1_a), .In_rwbar1(rwbar1_a), .In_addr1(addr1_a), .In_wdata1(wdata1_a),
        .Out_ack1(ack1_a), .Out_rdata1(rdata1_a),
        .Out_Mem_Access_en(en_a), .Out_Mem_Access_R_Wbar(rw_a),
        .Out_Mem_Access_addr(maddr_a), .Out_Mem_Write_data(mwdata_a),
        .In_Mem_Read_data(mrdata_a), .Out_busy(busy_a)
    );

    mem_port_arbiter #(.MEM_LAT(3)) u_dut_b (
        .clk(clk), .In_reset(rst_n),
        .In_req0(req0_b), .In_rwbar0(rwbar0_b), .In_addr0(addr0_b), .In_wdata0(wdata0_b),
        .Out_ack0(ack0_b), .Out_rdata0(rdata0_b),
        .In_req1(req1_b), .In_rwbar1(rwbar1_b), .In_addr1(addr1_b), .In_wdata1(wdata1_b),
        .Out_ack1(ack1_b), .Out_rdata1(rdata1_b),
        .Out_Mem_Access_en(en_b), .Out_Mem_Access_R_Wbar(rw_b),
        .Out_Mem_Access_addr(maddr_b), .Out_Mem_Write_data(mwdata_b),
        .In_Mem_Read_data(mrdata_b), .Out_busy(busy_b)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    initial begin
        int order [0:3];
        int n_ord;
        logic [15:0] got_r0;
        int en_cnt, first_en, last_en, busy_cnt, ack_at, ack_cnt, ack1_cnt;
        int acks, acks0, id, exp_id, last_m;

        {req0_a, req1_a, req0_b, req1_b} = 4'b0000;
        {rwbar0_a, rwbar1_a, rwbar0_b, rwbar1_b} = 4'b1111;
        {addr0_a, wdata0_a, addr1_a, wdata1_a} = 64'h0;
        {addr0_b, wdata0_b, addr1_b, wdata1_b} = 64'h0;
        rst_n = 1'b0;
        tick();
        tick();

        // Reset state
        check("rst_en", en_a, 1'b0);
        check("rst_rwbar", rw_a, 1'b1);
        check("rst_acks", {ack0_a, ack1_a}, 2'b00);
        check("rst_busy", busy_a, 1'b0);
        check("rst_addr", maddr_a, 16'd0);
        check("rst_rdata0", rdata0_a, 16'd0);
        rst_n = 1'b1;
        tick();

        // Port 1 write 23 @ 17
        req1_a = 1'b1; rwbar1_a = 1'b0; addr1_a = 16'd17; wdata1_a = 16'd23;
        tick();
        check("w_en", en_a, 1'b1);
        check("w_rwbar", rw_a, 1'b0);
        check("w_addr", maddr_a, 16'd17);
        check("w_wdata", mwdata_a, 16'd23);
        check("w_busy", busy_a, 1'b1);
        check("w_ack1_early", ack1_a, 1'b0);
        tick();
        check("w_ack1", ack1_a, 1'b1);
        check("w_ack0", ack0_a, 1'b0);
        check("w_en_done", en_a, 1'b0);
        req1_a = 1'b0;
        tick();
        check("w_ack1_once", ack1_a, 1'b0);
        check("w_busy_idle", busy_a, 1'b0);
        check("w_rwbar_idle", rw_a, 1'b1);

        // Port 0 read back @ 17
        req0_a = 1'b1; rwbar0_a = 1'b1; addr0_a = 16'd17;
        tick();
        check("r_en", en_a, 1'b1);
        check("r_rwbar", rw_a, 1'b1);
        check("r_addr", maddr_a, 16'd17);
        tick();
        check("r_ack0", ack0_a, 1'b1);
        check("r_ack1", ack1_a, 1'b0);
        check("r_rdata0", rdata0_a, 16'd23);
        check("r_rdata1", rdata1_a, 16'd0);
        req0_a = 1'b0;
        tick();

        // MEM_LAT=3 read @ 30
        req0_b = 1'b1; rwbar0_b = 1'b1; addr0_b = 16'd30;
        en_cnt = 0; first_en = 0; last_en = 0; busy_cnt = 0; ack_at = 0; ack_cnt = 0; ack1_cnt = 0;
        for (int k = 1; k <= 8; k++) begin
            tick();
            if (en_b) begin
                en_cnt++;
                if (first_en == 0) first_en = k;
                last_en = k;
            end
            if (busy_b) busy_cnt++;
            if (ack1_b) ack1_cnt++;
            if (ack0_b) begin
                ack_at = k;
                ack_cnt++;
                req0_b = 1'b0;
            end
        end
        check("l3_en_cnt", en_cnt, 3);
        check("l3_first_en", first_en, 1);
        check("l3_last_en", last_en, 3);
        check("l3_ack_at", ack_at, 4);
        check("l3_ack_cnt", ack_cnt, 1);
        check("l3_ack1_cnt", ack1_cnt, 0);
        check("l3_busy_cnt", busy_cnt, 4);
        check("l3_rdata0", rdata0_b, 16'hA5BB);

        // Reset during the 2nd ACCESS cycle
        req0_b = 1'b1; addr0_b = 16'd31;
        tick();
        check("ab_en1", en_b, 1'b1);
        tick();
        check("ab_en2", en_b, 1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        check("ab_en_async", en_b, 1'b0);
        check("ab_busy_async", busy_b, 1'b0);
        check("ab_ack_async", ack0_b, 1'b0);
        check("ab_rwbar_async", rw_b, 1'b1);
        req0_b = 1'b0;
        tick();
        rst_n = 1'b1;
        ack_cnt = 0; busy_cnt = 0;
        for (int k = 0; k < 6; k++) begin
            tick();
            if (ack0_b || ack1_b) ack_cnt++;
            if (busy_b || en_b) busy_cnt++;
        end
        check("ab_no_ack", ack_cnt, 0);
        check("ab_idle", busy_cnt, 0);
        check("ab_rdata0", rdata0_b, 16'd0);

        // Simultaneous requests straight after reset
        req0_a = 1'b1; rwbar0_a = 1'b1; addr0_a = 16'd0;
        req1_a = 1'b1; rwbar1_a = 1'b0; addr1_a = 16'd0; wdata1_a = 16'd13;
        n_ord = 0; got_r0 = 16'hFFFF;
        for (int k = 0; k < 20 && n_ord < 2; k++) begin
            tick();
            if (ack1_a && n_ord < 4) begin
                order[n_ord] = 1; n_ord++; req1_a = 1'b0;
            end
            if (ack0_a && n_ord < 4) begin
                order[n_ord] = 0; n_ord++; got_r0 = rdata0_a; req0_a = 1'b0;
            end
        end
        check("tie_n_acks", n_ord, 2);
`ifdef ARB_ROUND_ROBIN_EN
        check("tie_first", order[0], 0);
        check("tie_second", order[1], 1);
        check("tie_rdata0", got_r0, 16'd0);
`else
        check("tie_first", order[0], 1);
        check("tie_second", order[1], 0);
        check("tie_rdata0", got_r0, 16'd13);
`endif
        tick();

        // Both ports request continuously
        req0_a = 1'b0; req1_a = 1'b0;
        do_reset();
        req0_a = 1'b1; rwbar0_a = 1'b1; addr0_a = 16'd1;
        req1_a = 1'b1; rwbar1_a = 1'b1; addr1_a = 16'd2;
        acks = 0; acks0 = 0; last_m = 1;
        for (int k = 0; k < 15; k++) begin
            tick();
            if (ack0_a || ack1_a) begin
                id = ack1_a ? 1 : 0;
`ifdef ARB_ROUND_ROBIN_EN
                exp_id = (last_m == 1) ? 0 : 1;
                last_m = exp_id;
`else
                exp_id = 1;
`endif
                check("cont_grant_id", id, exp_id);
                acks++;
                if (ack0_a) acks0++;
            end
        end
        check("cont_acks", acks, 5);
`ifdef ARB_ROUND_ROBIN_EN
        check("cont_acks0", acks0, 3);
`else
        check("cont_acks0", acks0, 0);
`endif
        req0_a = 1'b0; req1_a = 1'b0;
        tick();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
